// File: rtl/binary_to_bcd_seq_pkg.sv
// Shared widths, counter limits and FSM encoding
// for the sequential binary-to-BCD converter.
package binary_to_bcd_seq_pkg;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/binary_to_bcd_seq_bcd_digit_adj.sv
// One double-dabble digit correction:
// add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) begin
      d_o = d_i + 4'd3;
    end
  end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential double-dabble converter: one
// adjust-and-shift iteration per clock.
module binary_to_bcd_seq
  import binary_to_bcd_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int SH_W = BCD_W + BIN_W;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] scr_q, scr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  logic [BCD_W-1:0] scr_adj;
  logic [SH_W-1:0]  sh;
  logic [BCD_W-1:0] scr_nxt;
  logic [BIN_W-1:0] bin_nxt;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (scr_q[4*g +: 4]),
      .d_o (scr_adj[4*g +: 4])
    );
  end

  always_comb begin
    sh      = {scr_adj, bin_q} << 1;
    scr_nxt = sh[SH_W-1:BIN_W];
    bin_nxt = sh[BIN_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = '0;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        bin_d = bin_nxt;
        scr_d = scr_nxt;
        cnt_d = cnt_q + 1'b1;
        // Only the final iteration reaches the output.
        if (cnt_q == CNT_LAST) begin
          bcd_d   = scr_nxt;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = (state_q == S_CONV);
  assign done    = (state_q == S_DONE);
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Scoreboard bench for binary_to_bcd_seq:
// latency, ignore-in-CONV, back-to-back, abort, sweep.
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;

  int errors = 0;
  int checks = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  binary_to_bcd_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  function automatic logic [19:0] ref_bcd(input int v);
    int t;
    logic [19:0] r;
    t = v;
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b1;
    bin_in = 16'd1234;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: busy/done=%b want 00", {busy, done});
    end
    checks++;
    if (bcd_out !== 20'h0) begin
      errors++;
      $display("FAIL reset_bcd: got %h want 00000", bcd_out);
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic run_one(input logic [15:0] v, output int lat);
    logic [19:0] e;
    int bad;
    @(negedge clk);
    start = 1'b1;
    bin_in = v;
    sb.push_back(ref_bcd(int'(v)));
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout_%0d: no done after %0d cycles", v, lat);
    end else begin
      e = sb.pop_front();
      checks++;
      if (bcd_out !== e) begin
        errors++;
        $display("FAIL value_%0d: got %h want %h", v, bcd_out, e);
      end
      bad = 0;
      for (int i = 0; i < 5; i++)
        if (bcd_out[4*i +: 4] > 4'd9) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL digits_%0d: %h has %0d digits >9", v, bcd_out, bad);
      end
    end
  endtask

  task automatic test_latency;
    int lat;
    run_one(16'd0, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL latency_zero: got %0d want 16 after accept", lat);
    end
  endtask

  task automatic test_values;
    int lat;
    logic [15:0] vals[9];
    vals = '{16'd1234, 16'd65535, 16'd50, 16'd9, 16'd10,
             16'd99, 16'd100, 16'd9999, 16'd10000};
    foreach (vals[i]) begin
      run_one(vals[i], lat);
      checks++;
      if (lat != 16) begin
        errors++;
        $display("FAIL latency_%0d: got %0d want 16", vals[i], lat);
      end
    end
  endtask

  task automatic test_ignore_in_conv;
    int n;
    logic [19:0] e;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd999;
    sb.push_back(ref_bcd(999));
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'd3;
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin_in = 16'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int k = 6; k < 46; k++) begin
      @(negedge clk);
      if (done) begin
        n++;
        if (n == 1) begin
          e = sb.pop_front();
          checks++;
          if (bcd_out !== e) begin
            errors++;
            $display("FAIL ignore_value: got %h want %h", bcd_out, e);
          end
          checks++;
          if (k != 16) begin
            errors++;
            $display("FAIL ignore_latency: got %0d want 16", k);
          end
        end
      end
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL ignore_count: %0d done pulses want 1", n);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic [19:0] e;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd4321;
    sb.push_back(ref_bcd(4321));
    @(negedge clk);
    bin_in = 16'd42;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!done || k != 16) begin
      errors++;
      $display("FAIL b2b_first: done=%b at %0d want 1 at 16", done, k);
    end
    if (done) begin
      e = sb.pop_front();
      checks++;
      if (bcd_out !== e) begin
        errors++;
        $display("FAIL b2b_first_value: got %h want %h", bcd_out, e);
      end
    end
    sb.push_back(ref_bcd(42));
    @(negedge clk);
    start = 1'b0;
    bin_in = 16'hffff;
    k = 1;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!done || k != 17) begin
      errors++;
      $display("FAIL b2b_second: done=%b at %0d want 1 at 17", done, k);
    end
    if (done) begin
      e = sb.pop_front();
      checks++;
      if (bcd_out !== e) begin
        errors++;
        $display("FAIL b2b_second_value: got %h want %h", bcd_out, e);
      end
    end
  endtask

  task automatic test_reset_abort;
    int n;
    int lat;
    @(negedge clk);
    start = 1'b1;
    bin_in = 16'd500;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || bcd_out !== 20'h0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b bcd=%h want 0 0 00000",
               busy, done, bcd_out);
    end
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL abort_done: %0d done pulses want 0", n);
    end
    run_one(16'd500, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL abort_rerun_latency: got %0d want 16", lat);
    end
  endtask

  task automatic test_sweep;
    int lat;
    for (int v = 0; v < 65536; v += 37) begin
      run_one(16'(v), lat);
    end
    run_one(16'd65535, lat);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    test_reset();
    test_latency();
    test_values();
    test_ignore_in_conv();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 Parameters: none; width constants SHALL come from the shared package (BIN_W=16, DIGITS=5).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request a conversion of bin_in; sampled on the rising edge.
REQ-005 bin_in  input  16  unsigned binary operand; sampled only on the edge where start is accepted.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking a new valid result on bcd_out.
REQ-008 bcd_out  output  20  five packed BCD digits, [19:16] ten-thousands ... [3:0] units; feeds the downstream Excess-3 stage.

Function
REQ-009 The FSM SHALL have states IDLE, CONV and DONE.
REQ-010 In IDLE or DONE with start=1, the block SHALL load bin_in into the binary shift register, clear the 20-bit BCD scratch register and bit counter, and enter CONV.
REQ-011 Each CONV cycle SHALL perform one double-dabble iteration: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one.
REQ-012 After exactly 16 CONV cycles the result SHALL be written to bcd_out and the FSM SHALL enter DONE.
REQ-013 Latency: when start is accepted on edge E0, done SHALL be high during the cycle after edge E16 (17 cycles), and busy SHALL be high from E0 through E16.
REQ-014 In DONE with start=0, done SHALL be high for that one cycle and the FSM SHALL return to IDLE.
REQ-015 Start in DONE SHALL be accepted (back-to-back conversions): done still pulses for that cycle and the next conversion begins.
REQ-016 Start while in CONV SHALL be ignored; the operand and progress SHALL be unaffected.
REQ-017 bcd_out SHALL hold the last completed result until the next completion and SHALL never show intermediate scratch values.
REQ-018 Every bcd_out digit SHALL be in the range 0..9; 65535 SHALL convert to 0x65535 with no overflow.
REQ-019 bin_in changes outside the accepting edge SHALL have no effect.

Reset
REQ-020 While rst=1 on a clock edge, the FSM SHALL go to IDLE and busy, done and bcd_out SHALL all be cleared to 0. Scratch registers and the counter SHALL also be cleared.
REQ-021 Reset SHALL override start on the same edge.
REQ-022 Reset during CONV SHALL abort the conversion; no done pulse SHALL follow.

Structure
REQ-023 A shared package SHALL hold BIN_W, DIGITS, BCD_W=4*DIGITS, the counter width, and the FSM state enumeration.
REQ-024 A single sub-module bcd_digit_adj SHALL implement the add-3-if-≥5 function on one 4-bit digit. It SHALL be instantiated DIGITS times.
REQ-025 The datapath SHALL be one adjust stage per cycle; a fully unrolled combinational implementation SHALL NOT be used.

Verification
REQ-026 bin_in=0, start pulse -> done exactly 17 cycles later, bcd_out=0x00000.
REQ-027 bin_in=1234 -> bcd_out=0x01234; bin_in=65535 -> bcd_out=0x65535; bin_in=50 -> 0x00050.
REQ-028 bin_in=999, start; start re-asserted with bin_in=7 on cycle 5 -> exactly one done, bcd_out=0x00999.
REQ-029 start with 4321 held through the DONE cycle with bin_in=42 -> done for 4321 (0x04321), then a second done 17 cycles later with 0x00042.
REQ-030 bin_in=500, start; rst on cycle 8 -> busy=0, bcd_out=0, no done; a later start with 500 -> 0x00500.
REQ-031 Sweep 0..65535 against a reference model -> every result matches and every digit is <= 9.
